// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encodings
// and the architectural zero register name.
package pipe_ctrl_pkg;

  localparam int STATE_W  = 3;
  localparam int REG_ZERO = 0;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard comparator: a load in EX whose destination feeds the
// instruction currently in ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int RBITS = 5
) (
  input  logic [RBITS-1:0] id_rs,
  input  logic [RBITS-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [RBITS-1:0] ex_rt,
  output logic             o_stall
);

  // Writes to the zero register are discarded, so they never create a dependency.
  assign o_stall = ex_memread && (ex_rt != RBITS'(REG_ZERO)) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline with a run/step/drain/halt
// debug FSM. Define PERF_COUNTERS_EN to build the cycle and stall counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RBITS        = 5,
  parameter int CBITS        = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_run,
  input  logic               i_step,
  input  logic               i_clear,
  input  logic               i_id_halt,
  input  logic [RBITS-1:0]   i_id_rs,
  input  logic [RBITS-1:0]   i_id_rt,
  input  logic               i_id_uses_rt,
  input  logic               i_ex_memread,
  input  logic [RBITS-1:0]   i_ex_rt,
  input  logic               i_branch_taken,
  output logic               o_pipe_en,
  output logic               o_pc_write,
  output logic               o_ifid_write,
  output logic               o_ifid_flush,
  output logic               o_idex_nop,
  output logic               o_halted,
  output logic [STATE_W-1:0] o_state,
  output logic [CBITS-1:0]   o_cycle_cnt,
  output logic [CBITS-1:0]   o_stall_cnt
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  state_e        state;
  logic [DW-1:0] drain_cnt;
  logic          hazard;
  logic          stall;

  hazard_detect #(.RBITS(RBITS)) u_hazard_detect (
    .id_rs      (i_id_rs),
    .id_rt      (i_id_rt),
    .id_uses_rt (i_id_uses_rt),
    .ex_memread (i_ex_memread),
    .ex_rt      (i_ex_rt),
    .o_stall    (hazard)
  );

  // Hazards only matter while instructions are actually advancing through ID.
  assign stall = hazard && ((state == ST_RUN) || (state == ST_STEP));

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    o_pipe_en    = 1'b0;
    o_pc_write   = 1'b0;
    o_ifid_write = 1'b0;
    o_ifid_flush = 1'b0;
    o_idex_nop   = 1'b0;
    case (state)
      ST_RUN, ST_STEP: begin
        o_pipe_en = 1'b1;
        if (stall) begin
          o_idex_nop = 1'b1;
        end else begin
          o_pc_write   = 1'b1;
          o_ifid_write = 1'b1;
          o_ifid_flush = !i_id_halt && i_branch_taken;
        end
      end
      ST_DRAIN: begin
        // Older instructions keep retiring while nothing new enters the pipe.
        o_pipe_en    = 1'b1;
        o_ifid_write = 1'b1;
        o_ifid_flush = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_run)       state <= ST_RUN;
          else if (i_step) state <= ST_STEP;
        end
        ST_RUN, ST_STEP: begin
          if (!stall && i_id_halt) begin
            state     <= ST_DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES);
          end else if (state == ST_STEP || !i_run) begin
            state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt - DW'(1);
          if (drain_cnt == DW'(1)) state <= ST_HALTED;
        end
        ST_HALTED: begin
          if (i_clear) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_halted = (state == ST_HALTED);
  assign o_state  = state;

`ifdef PERF_COUNTERS_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_cycle_cnt <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (o_pipe_en) o_cycle_cnt <= o_cycle_cnt + CBITS'(1);
      if (stall)     o_stall_cnt <= o_stall_cnt + CBITS'(1);
    end
  end
`else
  assign o_cycle_cnt = '0;
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a cycle model pushes expected
// outputs to a scoreboard queue, and each DUT sample pops and compares.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run, step, clear, id_halt, id_uses_rt, ex_memread, branch_taken;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        pipe_en, pc_write, ifid_write, ifid_flush, idex_nop, halted;
  logic [2:0]  state;
  logic [31:0] cycle_cnt, stall_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  st;
    logic        en, pcw, ifw, fl, nop, hlt;
    logic [31:0] cyc, stl;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [2:0]  m_st;
  int          m_drain;
  logic [31:0] m_cyc, m_stl;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .i_clk          (clk),
    .i_rst          (rst_n),
    .i_run          (run),
    .i_step         (step),
    .i_clear        (clear),
    .i_id_halt      (id_halt),
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_id_uses_rt   (id_uses_rt),
    .i_ex_memread   (ex_memread),
    .i_ex_rt        (ex_rt),
    .i_branch_taken (branch_taken),
    .o_pipe_en      (pipe_en),
    .o_pc_write     (pc_write),
    .o_ifid_write   (ifid_write),
    .o_ifid_flush   (ifid_flush),
    .o_idex_nop     (idex_nop),
    .o_halted       (halted),
    .o_state        (state),
    .o_cycle_cnt    (cycle_cnt),
    .o_stall_cnt    (stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 3'd0; m_drain = 0; m_cyc = '0; m_stl = '0;
  endtask

  // Drive one cycle of inputs, score it against the model, then advance the clock.
  task automatic cyc(input logic r, input logic s, input logic c, input logic h,
                     input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                     input logic mr, input logic [4:0] xr, input logic br,
                     input string tag);
    logic hz, en, stl, act;
    exp_t e, got;
    run = r; step = s; clear = c; id_halt = h; id_rs = rs; id_rt = rt;
    id_uses_rt = ur; ex_memread = mr; ex_rt = xr; branch_taken = br;
    #1;
    hz  = mr && (xr != 5'd0) && ((xr == rs) || (ur && (xr == rt)));
    act = (m_st == 3'd1) || (m_st == 3'd2);
    en  = act || (m_st == 3'd3);
    stl = hz && act;
    e.st  = m_st;
    e.en  = en;
    e.pcw = act && !stl;
    e.ifw = en && !stl;
    e.fl  = (m_st == 3'd3) || (act && !stl && !h && br);
    e.nop = stl;
    e.hlt = (m_st == 3'd4);
`ifdef PERF_COUNTERS_EN
    e.cyc = m_cyc;
    e.stl = m_stl;
`else
    e.cyc = '0;
    e.stl = '0;
`endif
    sb.push_back(e);

    got = sb.pop_front();
    check({tag, ".state"},      32'(state),      32'(got.st));
    check({tag, ".pipe_en"},    32'(pipe_en),    32'(got.en));
    check({tag, ".pc_write"},   32'(pc_write),   32'(got.pcw));
    check({tag, ".ifid_write"}, 32'(ifid_write), 32'(got.ifw));
    check({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(got.fl));
    check({tag, ".idex_nop"},   32'(idex_nop),   32'(got.nop));
    check({tag, ".halted"},     32'(halted),     32'(got.hlt));
    check({tag, ".cycle_cnt"},  cycle_cnt,       got.cyc);
    check({tag, ".stall_cnt"},  stall_cnt,       got.stl);

    if (en)  m_cyc = m_cyc + 32'd1;
    if (stl) m_stl = m_stl + 32'd1;
    case (m_st)
      3'd0: m_st = r ? 3'd1 : (s ? 3'd2 : 3'd0);
      3'd1, 3'd2: begin
        if (!stl && h) begin m_st = 3'd3; m_drain = 4; end
        else if (m_st == 3'd2 || !r) m_st = 3'd0;
      end
      3'd3: begin
        if (m_drain == 1) m_st = 3'd4;
        m_drain--;
      end
      default: if (c) m_st = 3'd0;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc(input string tag);
    cyc(0, 0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, tag);
  endtask

  task automatic run_cyc(input string tag);
    cyc(1, 0, 0, 0, 5'd1, 5'd2, 1, 0, 5'd0, 0, tag);
  endtask

  initial begin
    rst_n = 1'b0;
    run = 0; step = 0; clear = 0; id_halt = 0; id_rs = '0; id_rt = '0;
    id_uses_rt = 0; ex_memread = 0; ex_rt = '0; branch_taken = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    idle_cyc("reset");
    // Run: first cycle is still IDLE, then 10 pipelined cycles.
    run_cyc("run_enter");
    for (int i = 0; i < 10; i++) run_cyc("run");

    // Load-use on rs, then the non-hazard variants, then rt with uses_rt.
    cyc(1, 0, 0, 0, 5'd8, 5'd3, 0, 1, 5'd8, 0, "lu_rs");
    cyc(1, 0, 0, 0, 5'd0, 5'd3, 1, 1, 5'd0, 0, "lu_zero");
    cyc(1, 0, 0, 0, 5'd4, 5'd8, 0, 1, 5'd8, 0, "lu_rt_unused");
    cyc(1, 0, 0, 0, 5'd4, 5'd8, 1, 1, 5'd8, 0, "lu_rt_used");
    cyc(1, 0, 0, 0, 5'd8, 5'd3, 0, 0, 5'd8, 0, "no_memread");

    // Load-use masks a taken branch; the retried branch then flushes.
    cyc(1, 0, 0, 0, 5'd9, 5'd3, 0, 1, 5'd9, 1, "lu_branch");
    cyc(1, 0, 0, 0, 5'd9, 5'd3, 0, 0, 5'd9, 1, "branch");
    // Load-use masks a halt too.
    cyc(1, 0, 0, 1, 5'd9, 5'd3, 0, 1, 5'd9, 0, "lu_halt");

    for (int i = 0; i < 40; i++)
      cyc(1, 0, 0, 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rand");

    // Halt with branch in the same cycle: halt wins, then drain with i_run toggling.
    cyc(1, 0, 0, 1, 5'd1, 5'd2, 0, 0, 5'd0, 1, "halt");
    for (int i = 0; i < 4; i++) cyc(1'(i % 2), 1'(i == 1), 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, "drain");
    cyc(1, 1, 0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, "halted_ignore");
    cyc(0, 0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, "halted_hold");
    cyc(0, 0, 1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, "clear");
    idle_cyc("after_clear");

    // Single step, plain then stalled, then step with halt.
    cyc(0, 1, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, "step_req");
    idle_cyc("step_exec");
    idle_cyc("step_done");
    cyc(0, 1, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, "step_req2");
    cyc(0, 0, 0, 0, 5'd7, 5'd0, 0, 1, 5'd7, 0, "step_stall");
    idle_cyc("step_stall_done");
    cyc(1, 1, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, "run_over_step");
    cyc(0, 0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, "run_drop");
    cyc(0, 1, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, "step_req3");
    cyc(0, 0, 0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, "step_halt");
    for (int i = 0; i < 4; i++) idle_cyc("step_drain");
    cyc(0, 0, 1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, "clear2");

    // Asynchronous reset in the middle of DRAIN.
    run_cyc("run_enter2");
    cyc(1, 0, 0, 1, 5'd1, 5'd2, 0, 0, 5'd0, 0, "halt2");
    idle_cyc("drain2");
    rst_n = 1'b0;
    #1;
    check("async_rst.state", 32'(state), 32'd0);
    check("async_rst.pipe_en", 32'(pipe_en), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cyc("post_rst");
    run_cyc("run_enter3");
    run_cyc("run3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
